// File: rtl/pc_unit.sv
// Program counter for the fetch stage: next-PC selection,
// run/halt/step debug control and address breakpoints.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180,
  parameter int INC = 4,
  parameter int NUM_BP = 4,
  parameter int BPW = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pcwrite,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_valid,
  input  logic             dbg_halt_req,
  input  logic             dbg_resume,
  input  logic             dbg_step,
  input  logic             bp_wr_en,
  input  logic [BPW-1:0]   bp_wr_idx,
  input  logic [WIDTH-1:0] bp_wr_addr,
  input  logic             bp_wr_enable,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus,
  output logic             halted,
  output logic             bp_hit,
  output logic [BPW-1:0]   bp_hit_idx
);

  localparam logic [WIDTH-1:0] EXC_W = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    STEP   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             skip_q, skip_d;
  logic             hit_q, hit_d;
  logic [BPW-1:0]   idx_q, idx_d;
  logic             halted_q;

  logic             bp_en_q   [NUM_BP];
  logic [WIDTH-1:0] bp_addr_q [NUM_BP];

  logic             match;
  logic [BPW-1:0]   match_idx;
  logic             upd;
  logic [WIDTH-1:0] cand;

  assign pc_plus    = pc_q + INC_W;
  assign pc         = pc_q;
  assign halted     = halted_q;
  assign bp_hit     = hit_q;
  assign bp_hit_idx = idx_q;

  // Breakpoint compare; scan high to low so the lowest slot wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (bp_en_q[i] && (bp_addr_q[i] == pc_q)) begin
        match     = 1'b1;
        match_idx = BPW'(i);
      end
    end
  end

  // Next-PC candidate and debug state machine.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    skip_d  = skip_q;
    hit_d   = 1'b0;
    idx_d   = idx_q;
    upd     = exc_valid | pcwrite;
    if (exc_valid) begin
      cand = EXC_W;
    end else if (redirect_valid) begin
      cand = redirect_pc;
    end else begin
      cand = pc_plus;
    end
    case (state_q)
      RUN: begin
        if (exc_valid) begin
          pc_d   = EXC_W;
          skip_d = 1'b0;
        end else if (dbg_halt_req) begin
          state_d = HALTED;
        end else if (match && !skip_q) begin
          state_d = HALTED;
          hit_d   = 1'b1;
          idx_d   = match_idx;
        end else if (upd) begin
          pc_d   = cand;
          skip_d = 1'b0;
        end
      end
      HALTED: begin
        if (dbg_resume) begin
          state_d = RUN;
          skip_d  = 1'b1;
        end else if (dbg_step) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (upd) begin
          pc_d    = cand;
          skip_d  = 1'b0;
          state_d = HALTED;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Core state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      pc_q     <= RESET_VECTOR;
      skip_q   <= 1'b0;
      hit_q    <= 1'b0;
      idx_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      skip_q   <= skip_d;
      hit_q    <= hit_d;
      idx_q    <= idx_d;
      halted_q <= (state_d == HALTED);
    end
  end

  // Breakpoint slots; out-of-range indices match no slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_BP; i++) begin
        bp_en_q[i]   <= 1'b0;
        bp_addr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BP; i++) begin
        if (bp_wr_en && (bp_wr_idx == BPW'(i))) begin
          bp_en_q[i]   <= bp_wr_enable;
          bp_addr_q[i] <= bp_wr_addr;
        end
      end
    end
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS fetch stage, replacing the fixed 32-bit PC register. It selects the next PC by fixed priority: exception vector, then branch/jump redirect, then sequential increment. It adds a debug controller with a run/halt/single-step state machine and NUM_BP programmable address breakpoints. It drives the instruction-memory address and exports halt/breakpoint status to the debug front end.

## Interface
- WIDTH, 32: PC width in bits.
- RESET_VECTOR, 0: PC value after reset.
- EXC_VECTOR, 32'h0000_0180: exception entry address, truncated to WIDTH.
- INC, 4: sequential increment.
- NUM_BP, 4: number of breakpoint comparators, 1..16. BPW = max(1, $clog2(NUM_BP)).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- pcwrite  in  1  hazard unit permits a sequential or redirect update.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  WIDTH  branch/jump target.
- exc_valid  in  1  exception; loads EXC_VECTOR even when pcwrite=0.
- dbg_halt_req  in  1  request halt (level or pulse).
- dbg_resume  in  1  leave HALTED.
- dbg_step  in  1  execute one PC update, then halt again.
- bp_wr_en  in  1  write breakpoint slot.
- bp_wr_idx  in  BPW  slot index; values ≥ NUM_BP are ignored.
- bp_wr_addr  in  WIDTH  breakpoint address.
- bp_wr_enable  in  1  enable bit for the slot.
- pc  out  WIDTH  current PC (registered).
- pc_plus  out  WIDTH  pc+INC, combinational.
- halted  out  1  state is HALTED (registered).
- bp_hit  out  1  one-cycle pulse on breakpoint-caused halt.
- bp_hit_idx  out  BPW  slot that caused the last breakpoint halt; holds until the next hit.

## Operation
- States: RUN, HALTED, STEP. A skip_bp flag suppresses re-triggering on the same address after resume.
- Next-PC candidate: exc_valid → EXC_VECTOR; else if redirect_valid → redirect_pc; else pc_plus. Sum wraps mod 2^WIDTH.
- Update enable: exc_valid OR pcwrite.
- bp_match: any slot with enable=1 and addr==pc. When several slots match, the lowest index is reported.
- **RUN** (priority order):
  1. exc_valid: take the exception; no halt this cycle.
  2. dbg_halt_req: go to HALTED; pc holds.
  3. bp_match AND NOT skip_bp: go to HALTED; pc holds; bp_hit=1; latch bp_hit_idx.
  4. Otherwise, update pc if enabled. Clear skip_bp on any pc update.
- **HALTED**:
  - pc holds; exc_valid, redirect_valid and pcwrite are ignored.
  - dbg_resume → RUN with skip_bp=1.
  - else dbg_step → STEP.
  - dbg_resume has priority over dbg_step.
- **STEP**:
  - Breakpoint compare and dbg_halt_req are ignored.
  - On the first cycle with the update enable set, load the next PC and return to HALTED.
  - While the enable is low, stay in STEP with pc held.
- Breakpoint writes are accepted in any state. A write takes effect for compares from the next cycle.

## Timing
- Reset values: pc=RESET_VECTOR, state=RUN, halted=0, bp_hit=0, bp_hit_idx=0, skip_bp=0, all slots disabled with addr=0.
- Reset asserted mid-STEP or while HALTED returns the unit to RUN immediately.
- All redirects have 1-cycle latency: inputs sampled at edge N give the new pc after edge N.
- Halt latency: request or match at edge N → halted=1 after edge N. pc is not advanced at edge N.
- bp_hit is high for exactly the cycle following the halting edge.
- Resume at edge N → RUN after edge N. The first update after that leaves the breakpoint address without a re-hit.
- A step from HALTED takes ≥2 edges: HALTED→STEP, then STEP→HALTED with the pc update.
- pc_plus is combinational from pc; there is no other combinational path to outputs.

## Test plan
- **Reset and sequential run:** release rst_n, pcwrite=1 for 3 cycles → pc 0, 4, 8, 12. Assert rst_n low mid-run → pc=0 asynchronously.
- **Redirect priority:** pc=0x40; exc_valid=1 and redirect_valid=1 with redirect_pc=0x100, pcwrite=0 → pc=0x180. Next, redirect only with pcwrite=1 → pc=0x100.
- **Breakpoint and resume:**
  - Write slot 2 = 0x8, enabled; run from 0 → pc stops at 0x8, halted=1, bp_hit pulses once, bp_hit_idx=2.
  - dbg_resume → pc 0xC on the next update, no second hit.
- **Multiple matches:** slots 1 and 3 both set to 0x10, enabled → bp_hit_idx=1.
- **Single step:**
  - Halt at 0x20; dbg_step with pcwrite=0 for 2 cycles → pc stays 0x20 in STEP.
  - Then pcwrite=1 → pc=0x24, halted=1.
  - dbg_step and dbg_resume together → RUN.
- **Wrap and halted isolation:**
  - WIDTH=8, INC=4, pc=0xFC, pcwrite=1 → pc=0x00.
  - While HALTED, exc_valid=1 → pc unchanged.
